// File: rtl/cache_2way.sv
// cache_2way: 2-way set-associative write-back cache between a CPU port and a BurstRAM.
// Lines are 32 B (8 x 32-bit words), moved as 4 x 64-bit bursts. Per-set LRU replacement,
// write-back of dirty victims only, and a whole-cache flush command.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   address           byte address (word aligned); data_in / write_enable for writes
//   data_out          read (or merged write) data, valid while data_out_ready=1
//   flush, flush_done flush request pulse (sampled while busy=0), completion pulse
//   busy              cache not accepting requests
//   br_*              BurstRAM command/data interface (br_addr in 8-byte units)
module cache_2way #(
    parameter int unsigned LINE_IX_BITWIDTH         = 1,
    parameter int unsigned BURST_RAM_DEPTH_BITWIDTH = 4,
    parameter int unsigned CYCLES_BEFORE_DATA_VALID = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [31:0]                         address,
    output logic [31:0]                         data_out,
    output logic                                data_out_ready,
    input  logic [31:0]                         data_in,
    input  logic [3:0]                          write_enable,
    input  logic                                flush,
    output logic                                flush_done,
    output logic                                busy,
    output logic                                br_cmd,
    output logic                                br_cmd_en,
    output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]                         br_wr_data,
    output logic [7:0]                          br_data_mask,
    input  logic [63:0]                         br_rd_data,
    input  logic                                br_rd_data_valid
);
    localparam int unsigned SETS  = 1 << LINE_IX_BITWIDTH;
    localparam int unsigned SET_W = LINE_IX_BITWIDTH;
    localparam int unsigned TAG_W = BURST_RAM_DEPTH_BITWIDTH - 2 - LINE_IX_BITWIDTH;
    localparam int unsigned IDX_W = LINE_IX_BITWIDTH + 1;

    typedef enum logic [2:0] {
        StIdle, StWb, StFillCmd, StFillWait, StFlScan, StFlWb
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       beat_q;
    logic             vway_q;
    logic [IDX_W-1:0] fl_idx_q;  // flush scan position {set, way}
    logic [31:0]      data_out_q;
    logic             ready_q;
    logic             flush_done_q;

    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  dirty_q [2];
    logic [SETS-1:0]  lru_q;  // way to evict next
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [31:0]      mem_q   [2][SETS][8];

    // Address decode; upper and byte-offset bits are deliberately ignored.
    logic [2:0]       req_word;
    logic [SET_W-1:0] req_set;
    logic [TAG_W-1:0] req_tag;
    logic             is_write;
    logic             unused_ok;

    assign req_word  = address[4:2];
    assign req_set   = address[4+LINE_IX_BITWIDTH:5];
    assign req_tag   = address[BURST_RAM_DEPTH_BITWIDTH+2:5+LINE_IX_BITWIDTH];
    assign is_write  = |write_enable;
    assign unused_ok = ^{address[31:BURST_RAM_DEPTH_BITWIDTH+3], address[1:0],
                         32'(CYCLES_BEFORE_DATA_VALID)};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

    // Lookup and victim selection
    logic [1:0] way_hit;
    logic       hit, hit_way, victim_way, victim_dirty;

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            way_hit[w] = valid_q[w][req_set] && (tag_q[w][req_set] == req_tag);
        end
    end

    assign hit     = |way_hit;
    assign hit_way = way_hit[1];

    always_comb begin
        if (!valid_q[0][req_set])      victim_way = 1'b0;
        else if (!valid_q[1][req_set]) victim_way = 1'b1;
        else                           victim_way = lru_q[req_set];
    end

    assign victim_dirty = valid_q[victim_way][req_set] && dirty_q[victim_way][req_set];

    // Flush scan and write-back line selection
    logic             fl_way, fl_dirty, fl_last;
    logic [SET_W-1:0] fl_set;
    logic             in_wb, wb_way;
    logic [SET_W-1:0] wb_set;

    assign fl_way   = fl_idx_q[0];
    assign fl_set   = fl_idx_q[IDX_W-1:1];
    assign fl_dirty = valid_q[fl_way][fl_set] && dirty_q[fl_way][fl_set];
    assign fl_last  = (fl_idx_q == '1);
    assign in_wb    = (state_q == StWb) || (state_q == StFlWb);
    assign wb_way   = (state_q == StFlWb) ? fl_way : vway_q;
    assign wb_set   = (state_q == StFlWb) ? fl_set : req_set;

    // Word values for servicing the request
    logic [31:0] hit_word, hit_merged, fill_word, fill_merged;

    assign hit_word   = mem_q[hit_way][req_set][req_word];
    assign hit_merged = merge_bytes(hit_word, data_in, write_enable);
    // The last beat is not in the array yet when the request is serviced.
    assign fill_word  = (req_word[2:1] == 2'd3)
                        ? (req_word[0] ? br_rd_data[63:32] : br_rd_data[31:0])
                        : mem_q[vway_q][req_set][req_word];
    assign fill_merged = merge_bytes(fill_word, data_in, write_enable);

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (flush)    state_d = StFlScan;
                else if (!hit) state_d = victim_dirty ? StWb : StFillCmd;
            end
            StWb:       if (beat_q == 2'd3) state_d = StFillCmd;
            StFillCmd:  state_d = StFillWait;
            StFillWait: if (br_rd_data_valid && beat_q == 2'd3) state_d = StIdle;
            StFlScan: begin
                if (fl_dirty)     state_d = StFlWb;
                else if (fl_last) state_d = StIdle;
            end
            StFlWb:     if (beat_q == 2'd3) state_d = StFlScan;
            default:    state_d = StIdle;
        endcase
    end

    // BurstRAM interface
    always_comb begin
        br_cmd     = 1'b0;
        br_cmd_en  = 1'b0;
        br_addr    = '0;
        br_wr_data = '0;
        if (in_wb) begin
            br_cmd     = 1'b1;
            br_cmd_en  = (beat_q == 2'd0);
            br_addr    = {tag_q[wb_way][wb_set], wb_set, 2'b00};
            br_wr_data = {mem_q[wb_way][wb_set][{beat_q, 1'b1}],
                          mem_q[wb_way][wb_set][{beat_q, 1'b0}]};
        end else if (state_q == StFillCmd) begin
            br_cmd_en = 1'b1;
            br_addr   = {req_tag, req_set, 2'b00};
        end
    end

    assign br_data_mask   = '0;
    assign busy           = !rst_n || (state_q != StIdle);
    assign data_out       = data_out_q;
    assign data_out_ready = ready_q;
    assign flush_done     = flush_done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            vway_q       <= 1'b0;
            fl_idx_q     <= '0;
            data_out_q   <= '0;
            ready_q      <= 1'b0;
            flush_done_q <= 1'b0;
            valid_q[0]   <= '0;
            valid_q[1]   <= '0;
            dirty_q[0]   <= '0;
            dirty_q[1]   <= '0;
            lru_q        <= '0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    beat_q   <= '0;
                    fl_idx_q <= '0;
                    if (flush) begin
                        ready_q <= 1'b0;
                    end else if (hit) begin
                        lru_q[req_set] <= ~hit_way;
                        ready_q        <= 1'b1;
                        if (is_write) begin
                            mem_q[hit_way][req_set][req_word] <= hit_merged;
                            dirty_q[hit_way][req_set]         <= 1'b1;
                            data_out_q                        <= hit_merged;
                        end else begin
                            data_out_q <= hit_word;
                        end
                    end else begin
                        ready_q <= 1'b0;
                        vway_q  <= victim_way;
                    end
                end
                StWb: beat_q <= beat_q + 2'd1;
                StFillCmd: beat_q <= '0;
                StFillWait: begin
                    if (br_rd_data_valid) begin
                        mem_q[vway_q][req_set][{beat_q, 1'b0}] <= br_rd_data[31:0];
                        mem_q[vway_q][req_set][{beat_q, 1'b1}] <= br_rd_data[63:32];
                        beat_q <= beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            tag_q[vway_q][req_set]   <= req_tag;
                            valid_q[vway_q][req_set] <= 1'b1;
                            lru_q[req_set]           <= ~vway_q;
                            ready_q                  <= 1'b1;
                            if (is_write) begin
                                // Placed after the beat writes so the merge wins.
                                mem_q[vway_q][req_set][req_word] <= fill_merged;
                                dirty_q[vway_q][req_set]         <= 1'b1;
                                data_out_q                       <= fill_merged;
                            end else begin
                                dirty_q[vway_q][req_set] <= 1'b0;
                                data_out_q               <= fill_word;
                            end
                        end
                    end
                end
                StFlScan: begin
                    beat_q <= '0;
                    if (!fl_dirty) begin
                        if (fl_last) begin
                            valid_q[0]   <= '0;
                            valid_q[1]   <= '0;
                            dirty_q[0]   <= '0;
                            dirty_q[1]   <= '0;
                            lru_q        <= '0;
                            flush_done_q <= 1'b1;
                        end else begin
                            fl_idx_q <= fl_idx_q + IDX_W'(1);
                        end
                    end
                end
                StFlWb: begin
                    beat_q <= beat_q + 2'd1;
                    // Cleaning the line lets the rescan of this slot move on.
                    if (beat_q == 2'd3) dirty_q[fl_way][fl_set] <= 1'b0;
                end
                default: beat_q <= '0;
            endcase
        end
    end

endmodule

// File: doc/cache_2way.md
Name: cache_2way

Overview:
- Parametrised 2-way set-associative write-back cache; successor to the direct-mapped cache.
- Sits between the CPU data/instruction port and the BurstRAM controller (SDRAM/BurstRAM model).
- Adds per-set LRU replacement, dirty-only write-back, and a full-cache flush command.
- Line size is 32 B (8 x 32-bit words), filled or evicted as 4 x 64-bit bursts.

Parameters:
- LINE_IX_BITWIDTH, 1: log2 of the number of sets.
- BURST_RAM_DEPTH_BITWIDTH, 4: BurstRAM address width, in 8-byte units.
- CYCLES_BEFORE_DATA_VALID, 1: informational only; the cache waits on br_rd_data_valid and never counts cycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- address  in  32  byte address; word-aligned accesses only
- data_out  out  32  read data
- data_out_ready  out  1  data_out is valid for the current address
- data_in  in  32  write data
- write_enable  in  4  byte-lane write strobes; 0 means read
- flush  in  1  one-cycle pulse, sampled only when busy=0
- flush_done  out  1  one-cycle pulse when a flush completes
- busy  out  1  cache is not accepting requests
- br_cmd  out  1  0 read, 1 write
- br_cmd_en  out  1  br_cmd and br_addr are valid
- br_addr  out  BURST_RAM_DEPTH_BITWIDTH  line base, 8-byte units, low 2 bits 0
- br_wr_data  out  64  write burst beat
- br_data_mask  out  8  always 0
- br_rd_data  in  64  read burst beat
- br_rd_data_valid  in  1  br_rd_data beat is valid

Behaviour:
- Address split: [1:0] byte, [4:2] word, [4+LINE_IX_BITWIDTH:5] set, tag = [BURST_RAM_DEPTH_BITWIDTH+2 : 5+LINE_IX_BITWIDTH]. Upper address bits are ignored.
- Per way and set: valid, dirty, tag, 8 words. Per set: one lru bit naming the way to evict next.
- Reset (rst_n=0 at a clk edge): every valid, dirty and lru bit cleared. Outputs: busy=1 for the reset cycle, then 0. data_out_ready=0, flush_done=0, br_cmd_en=0, br_cmd=0, br_addr=0, br_wr_data=0, br_data_mask=0.
- Reset mid-burst abandons the burst. No write-back is performed; dirty data is lost.
- A request is evaluated on every clk edge where busy=0. The requester changes address, data_in or write_enable only while busy=0.
- Read hit: data_out and data_out_ready=1 one cycle after the address is presented. The hit way becomes MRU (lru points to the other way).
- Write hit: selected byte lanes are updated at the evaluating edge and the line's dirty bit is set. busy stays 0. lru is updated. data_out_ready=1 next cycle with the merged word.
- Miss: busy=1 from the next cycle. data_out_ready=0 throughout. Victim = the invalid way if one exists (way 0 if both are invalid), else the lru way.
- State machine: IDLE -> (victim valid and dirty) WB -> FILL -> IDLE.
- WB: one cycle with br_cmd_en=1, br_cmd=1, br_addr=victim line base, beat 0 on br_wr_data. Beats 1..3 follow on consecutive cycles. Words are packed as {word[2k+1], word[2k]}.
- FILL: br_cmd_en=1, br_cmd=0 for one cycle. Each br_rd_data_valid beat k writes words 2k and 2k+1.
- After beat 3: tag written, valid=1, dirty=0, then the request is serviced as a hit.
  - Read: data_out_ready=1 and busy=0 on the same cycle.
  - Write: the merge is applied, dirty=1, busy=0.
- Clean victim: WB is skipped.
- br_cmd_en is never asserted while a burst is in progress.
- flush=1 with busy=0 takes priority over the current request. busy=1 from the next cycle.
- Flush scans every set and way in order (set-major, way 0 then way 1). Each valid dirty line gets a WB burst; then all valid, dirty and lru bits are cleared. flush_done pulses once and busy drops on the same cycle. The pending request is re-evaluated as a miss.
- flush while busy=1 is ignored.

Test Plan:
Setup for all scenarios: LINE_IX_BITWIDTH=1, BURST_RAM_DEPTH_BITWIDTH=5, BurstRAM preloaded so that the word at byte address a is 32'hA000_0000 + a/4.
- After reset, read 16 -> busy=1, exactly one read burst issued with br_addr=0, then data_out=32'hA0000004 with ready=1. A following read of 28 -> ready=1 after one cycle with 32'hA0000007 and no burst.
- Read 0, then read 64 (same set, way 1) -> both stay resident. Reads of 4 and 68 -> hits returning 32'hA0000001 and 32'hA0000011.
- Then read 128 -> evicts line 0 (LRU, clean), so no write burst and one read burst at br_addr=16. data_out=32'hA0000020. A later read of 0 misses.
- Write 8 with data_in=32'h000000AD, write_enable=4'b0001 -> read 8 returns 32'hA00000AD. Write 8 with data_in=32'hFEEF0000, write_enable=4'b1100 -> read 8 returns 32'hFEEF00AD.
- Dirty line 0 evicted by reads of 64 and then 128 -> write burst at br_addr=0 whose beat 1 is {32'hA0000003, 32'hFEEF00AD}, followed by the read burst. A re-read of 8 returns 32'hFEEF00AD.
- Two dirty lines in different sets, then a flush pulse -> exactly two write bursts, then a single flush_done pulse with busy=0 on the same cycle. A subsequent read of a flushed address misses and returns the written value.
